riscv_muldiv: RTL and testbench
===============================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; legal values are 8 to 64.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only when the unit is idle.
REQ-005 func3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 dataA  input  XLEN  rs1 operand: multiplicand or dividend.
REQ-007 dataB  input  XLEN  rs2 operand: multiplier or divisor.
REQ-008 kill  input  1  pipeline flush; aborts the operation in flight.
REQ-009 busy  output  1  operation in progress; drives the pipeline stall.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  XLEN  final value; held until the next accepted start.

Function
REQ-012 The unit SHALL implement states IDLE, CALC, FIX and DONE.
REQ-013 In IDLE or DONE, start=1 with kill=0 SHALL latch func3, dataA and dataB, then enter CALC (or FIX for a fast path).
REQ-014 Start is accepted cycle 0; busy SHALL be 1 in cycles 1..XLEN+1 and 0 otherwise; done SHALL be 1 only in cycle XLEN+2.
REQ-015 CALC SHALL run exactly XLEN iterations, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-016 FIX SHALL apply sign correction and result selection in one cycle, then enter DONE.
REQ-017 MUL SHALL return the low XLEN bits of the product; MULH the high XLEN bits of signed x signed; MULHSU the high bits of signed dataA x unsigned dataB; MULHU the high bits of unsigned x unsigned.
REQ-018 DIV/DIVU SHALL return the quotient truncated toward zero; REM/REMU the remainder, which takes the sign of the dividend.
REQ-019 Divisor 0 SHALL bypass CALC: quotient all ones, remainder = dataA; busy in cycle 1 only, done in cycle 2.
REQ-020 Signed DIV/REM with dataA = most-negative and dataB = -1 SHALL bypass CALC: quotient = dataA, remainder = 0; same timing as REQ-019.
REQ-021 start while busy=1 SHALL be ignored, with no effect on state, operands or result.
REQ-022 start in the DONE cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-023 kill=1 in any state SHALL return the unit to IDLE on the next edge: busy=0 and no done pulse; result is unchanged.
REQ-024 kill and start in the same cycle SHALL resolve to kill; the start is dropped.
REQ-025 Internal width SHALL be a 2*XLEN product/remainder accumulator plus an XLEN operand register and a counter of clog2(XLEN)+1 bits; there is no truncation before FIX.

Reset
REQ-026 clear=1 SHALL override start and kill and force IDLE, busy=0, done=0, result=0, with the counter and accumulators zeroed, on the next edge.
REQ-027 clear asserted mid-CALC SHALL abort the operation with no done pulse; the first start after clear is released SHALL behave as from power-up.

Verification (XLEN=32, start at cycle 0)
REQ-028 MUL: 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done=1 exactly in cycle 34, busy=1 in cycles 1..33.
REQ-029 MULH: 0x80000000 x 0x80000000 -> 0x40000000. MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV: 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM: same operands -> 0xFFFFFFFF. DIVU: 100 / 7 -> 14. REMU: 100 / 7 -> 2.
REQ-031 Fast paths: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0; each with done in cycle 2.
REQ-032 kill in cycle 10 -> busy=0 from cycle 11, no done, result keeps its prior value; clear in cycle 20 -> all outputs 0 in cycle 21.
REQ-033 start in cycles 5..33 ignored; a new start in cycle 34 (the done cycle) -> second done in cycle 68 with the correct second result.

Source files
------------

// File: rtl/riscv_muldiv.sv
// riscv_muldiv -- iterative RV32M/RV64M multiply/divide unit.
//
// Multiplies by unsigned shift-add and divides by restoring shift-subtract,
// one bit per cycle, always on operand magnitudes. A final FIX cycle applies
// the sign correction and picks the requested half of the result.
// Divide-by-zero and signed overflow skip the iterations and go straight to FIX.
//
// Ports:
//   clock        sole clock, rising edge
//   clear        synchronous active-high reset
//   start        request, sampled only in IDLE or DONE
//   func3        operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   dataA/dataB  rs1 / rs2 operands
//   kill         pipeline flush; aborts the operation in flight
//   busy         operation in progress (pipeline stall)
//   done         one-cycle pulse; result valid
//   result       final value, held until the next accepted start
//   dbg_state_o  current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
//
// Handshake: a request is taken on a rising edge where start=1, kill=0,
// clear=0 and the unit is in IDLE or DONE. busy then stays high until the
// cycle before done. done is high for exactly one cycle. A start seen while
// busy=1 is dropped with no effect.
module riscv_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] dataA,
   input  logic [XLEN-1:0] dataB,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      dbg_state_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        func3_q, func3_d;
   logic              neg_q, neg_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Decode of the incoming request.
   logic            in_div, sgn_a, sgn_b, a_neg, b_neg;
   logic            div_zero, div_ovf, accept;
   logic [XLEN-1:0] mag_a, mag_b;

   assign in_div = func3[2];
   // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
   // MUL uses unsigned magnitudes: the low half is the same either way.
   assign sgn_a  = in_div ? ~func3[0] : (func3[1] ^ func3[0]);
   assign sgn_b  = in_div ? ~func3[0] : (func3[1:0] == 2'b01);
   assign a_neg  = sgn_a & dataA[XLEN-1];
   assign b_neg  = sgn_b & dataB[XLEN-1];
   // Negating the most-negative value yields the same bit pattern, which is
   // the correct unsigned magnitude.
   assign mag_a  = a_neg ? -dataA : dataA;
   assign mag_b  = b_neg ? -dataB : dataB;

   assign div_zero = in_div & (dataB == '0);
   assign div_ovf  = in_div & ~func3[0] & (dataA == MOST_NEG) & (dataB == '1);
   assign accept   = start & ~kill & ((state_q == S_IDLE) || (state_q == S_DONE));

   // One multiply step: add the operand to the high half when the low bit is
   // set, then shift the whole accumulator right with the carry.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // One restoring divide step. The partial remainder is shifted into XLEN+1
   // bits so a remainder close to 2^XLEN is not lost. The quotient bit enters
   // at the bottom of the low half.
   logic [XLEN:0]     rem_sh, rem_diff;
   logic              rem_ge;
   logic [2*XLEN-1:0] div_next;
   assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign rem_diff = rem_sh - {1'b0, op_q};
   assign rem_ge   = ~rem_diff[XLEN];
   assign div_next = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                      acc_q[XLEN-2:0], rem_ge};

   // Sign correction and selection. The accumulator holds {remainder,
   // quotient} after a divide, and the full product after a multiply.
   logic [2*XLEN-1:0] fix_prod;
   logic [XLEN-1:0]   div_sel, div_fix;
   assign fix_prod = neg_q ? -acc_q : acc_q;
   assign div_sel  = func3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
   assign div_fix  = neg_q ? -div_sel : div_sel;

   always_comb begin
      state_d  = state_q;
      func3_d  = func3_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      case (state_q)
         S_CALC: begin
            cnt_d = cnt_q - CNT_ONE;
            acc_d = func3_q[2] ? div_next : mul_next;
            if (cnt_q == CNT_ONE) state_d = S_FIX;
         end
         S_FIX: begin
            if (func3_q[2])                result_d = div_fix;
            else if (func3_q[1:0] == 2'b00) result_d = fix_prod[XLEN-1:0];
            else                            result_d = fix_prod[2*XLEN-1:XLEN];
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = state_q;
      endcase

      if (accept) begin
         func3_d = func3;
         op_d    = mag_b;
         cnt_d   = CNT_LOAD;
         // A remainder takes the dividend's sign; quotient and product take the XOR.
         neg_d   = (in_div & func3[1]) ? a_neg : (a_neg ^ b_neg);
         acc_d   = {{XLEN{1'b0}}, mag_a};
         state_d = S_CALC;
         // Fast paths preload the final {remainder, quotient} pair unsigned.
         if (div_zero) begin
            acc_d   = {dataA, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            state_d = S_FIX;
         end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, dataA};
            neg_d   = 1'b0;
            state_d = S_FIX;
         end
      end

      // A flush wins over everything else, including a FIX write and a start.
      if (kill) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= S_IDLE;
         func3_q  <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         func3_q  <= func3_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign result      = result_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv at XLEN=32.
// Cycle numbering: the cycle in which start is driven is cycle 0. At each
// falling edge the outputs of the current cycle are sampled first, and the
// inputs for that cycle are driven afterwards.
module tb_riscv_muldiv;

   localparam int XLEN = 32;

   logic        clock, clear, start, kill;
   logic [2:0]  func3;
   logic [31:0] dataA, dataB;
   logic        busy, done;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   int n_cmp;
   int n_bad;

   riscv_muldiv #(.XLEN(XLEN)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .func3       (func3),
      .dataA       (dataA),
      .dataB       (dataB),
      .kill        (kill),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: RISC-V M-extension semantics with 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      int          ia, ib;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'd0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_done_cycle(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      if (f[2] && (b == 0)) return 2;
      if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
      return XLEN + 2;
   endfunction

   // ---------------- driver ----------------
   // Issue one operation and follow it to its done pulse, checking the busy
   // profile, the done cycle and the result. Returns at the done cycle's
   // falling edge, so a following call issues back-to-back.
   task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_done);
      int          cyc, got_cyc, busy_bad;
      logic [31:0] got_res;
      start = 1'b1; func3 = f; dataA = a; dataB = b;
      cyc = 0; got_cyc = -1; busy_bad = 0; got_res = '0;
      while (got_cyc < 0 && cyc < XLEN + 10) begin
         @(negedge clock);
         cyc++;
         start = 1'b0;
         if (done === 1'b1) begin
            got_cyc = cyc;
            got_res = result;
            if (busy !== 1'b0) busy_bad++;
         end else if (busy !== (cyc < exp_done)) begin
            busy_bad++;
         end
      end
      check({nm, " done_cycle"}, got_cyc, exp_done);
      check({nm, " busy_profile_errors"}, busy_bad, 0);
      check({nm, " result"}, got_res, exp_res);
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          done_cyc;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] held, r_a, r_b, op1_exp, op2_exp;
      logic [2:0]  r_f;
      int          done1, done2, busy_bad, sel;
      logic        done_seen;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
      vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};

      n_cmp = 0; n_bad = 0;
      // ---------------- reset (a pending start must not survive clear) ----
      clear = 1'b1; kill = 1'b0;
      start = 1'b1; func3 = 3'd5; dataA = 32'd5; dataB = 32'd0;
      repeat (3) @(negedge clock);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset result", result, 32'd0);
      check("reset state", dbg_state, 2'd0);
      clear = 1'b0; start = 1'b0;
      @(negedge clock);
      check("post-reset busy", busy, 1'b0);

      // ---------------- directed table ----------------
      for (int i = 0; i < 12; i++)
         do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
               vecs[i].exp, vecs[i].done_cyc);

      // ---------------- randomized against the model ----------------
      for (int i = 0; i < 40; i++) begin
         r_f = 3'($urandom_range(0, 7));
         r_a = $urandom;
         r_b = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) r_b = 32'd0;
         else if (sel == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
         else if (sel == 2) begin r_a = $urandom_range(0, 300); r_b = $urandom_range(1, 20); end
         else if (sel == 3) r_b = -($urandom_range(1, 20));
         do_op($sformatf("rand%0d f=%0d a=%h b=%h", i, r_f, r_a, r_b), r_f, r_a, r_b,
               ref_model(r_f, r_a, r_b), ref_done_cycle(r_f, r_a, r_b));
      end

      // ---------------- kill in cycle 10 ----------------
      do_op("pre-kill", 3'd5, 32'd100, 32'd7, 32'd14, 34);
      held = 32'd14;
      @(negedge clock);
      start = 1'b1; func3 = 3'd0; dataA = 32'd3; dataB = 32'd5;
      done_seen = 1'b0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         @(negedge clock);
         start = 1'b0;
         kill  = 1'b0;
         if (done === 1'b1) done_seen = 1'b1;
         if (cyc == 10) begin
            check("kill busy before", busy, 1'b1);
            kill = 1'b1;
         end
         if (cyc == 11) begin
            check("kill busy after", busy, 1'b0);
            check("kill state idle", dbg_state, 2'd0);
         end
      end
      check("kill no done", done_seen, 1'b0);
      check("kill result held", result, held);

      // ---------------- clear in cycle 20 ----------------
      start = 1'b1; func3 = 3'd5; dataA = 32'd1000; dataB = 32'd3;
      done_seen = 1'b0;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         @(negedge clock);
         start = 1'b0;
         clear = 1'b0;
         if (done === 1'b1) done_seen = 1'b1;
         if (cyc == 20) clear = 1'b1;
         if (cyc == 21) begin
            check("clear busy", busy, 1'b0);
            check("clear done", done, 1'b0);
            check("clear result", result, 32'd0);
         end
      end
      check("clear no done", done_seen, 1'b0);
      do_op("after-clear", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      @(negedge clock);

      // ---------------- ignored starts + back-to-back in the done cycle ----
      op1_exp = ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      op2_exp = ref_model(3'd7, 32'hDEAD_BEEF, 32'd97);
      start = 1'b1; func3 = 3'd1; dataA = 32'h1234_5678; dataB = 32'h9ABC_DEF0;
      done1 = -1; done2 = -1; busy_bad = 0;
      for (int cyc = 1; cyc <= 75; cyc++) begin
         @(negedge clock);
         start = 1'b0;
         if (done === 1'b1) begin
            if (done1 < 0) begin
               done1 = cyc;
               check("b2b first result", result, op1_exp);
            end else if (done2 < 0) begin
               done2 = cyc;
               check("b2b second result", result, op2_exp);
            end
         end else if (busy !== ((cyc <= 33) || (cyc >= 35 && cyc <= 67))) begin
            busy_bad++;
         end
         if (cyc >= 5 && cyc <= 33) begin
            start = 1'b1; func3 = 3'($urandom_range(0, 7));
            dataA = $urandom; dataB = $urandom_range(0, 3);
         end
         if (cyc == 34) begin
            start = 1'b1; func3 = 3'd7; dataA = 32'hDEAD_BEEF; dataB = 32'd97;
         end
      end
      check("b2b first done cycle", done1, 34);
      check("b2b second done cycle", done2, 68);
      check("b2b busy profile errors", busy_bad, 0);

      // ---------------- kill and start together ----------------
      @(negedge clock);
      start = 1'b1; kill = 1'b1; func3 = 3'd5; dataA = 32'd5; dataB = 32'd0;
      @(negedge clock);
      start = 1'b0; kill = 1'b0;
      check("kill+start busy c1", busy, 1'b0);
      @(negedge clock);
      check("kill+start done c2", done, 1'b0);
      check("kill+start result held", result, op2_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
